// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalise (S1) and round-to-nearest-even/pack (S2) for a single-precision adder.
// Optional macro FP_NR_FLAGS_EN adds out_flags = {overflow, underflow, inexact}.
module fp_norm_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] in_sum,
    input  logic [7:0]  in_exp,
    input  logic        in_sign,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FP_NR_FLAGS_EN
    ,
    output logic [2:0]  out_flags
`endif
);
    logic        v1_q, v2_q, adv1, adv2, carry;
    logic [4:0]  lz;
    logic [26:0] sh;
    logic        sign_d, zero_d, uf_d, g_d, r_d, s_d;
    logic        sign_q, zero_q, uf_q, g_q, r_q, s_q;
    logic [8:0]  exp_d, exp_q, exp_f;
    logic [23:0] man_d, man_q;
    logic [24:0] sum_m;
    logic        rnd, ovf;
    logic [31:0] res_d, res_q;
`ifdef FP_NR_FLAGS_EN
    logic [2:0]  flags_d, flags_q;
    assign out_flags = flags_q;
`endif

    assign adv2       = !v2_q || out_ready;
    assign adv1       = !v1_q || adv2;
    assign in_ready   = adv1;
    assign out_valid  = v2_q;
    assign out_result = res_q;

    // S1: carry-out shifts right one place, otherwise left-justify on the leading one
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) if (in_sum[i]) lz = 5'(26 - i);
        carry  = !in_sub && in_sum[27];
        sh     = in_sum[26:0] << lz;
        zero_d = !carry && in_sum[26:0] == '0;
        uf_d   = !carry && !zero_d && in_exp <= {3'b0, lz};
        sign_d = in_sign && !(zero_d && in_sub);
        exp_d  = carry ? {1'b0, in_exp} + 9'd1 : {1'b0, in_exp} - {4'b0, lz};
        man_d  = carry ? in_sum[27:4] : sh[26:3];
        g_d    = carry ? in_sum[3] : sh[2];
        r_d    = carry ? in_sum[2] : sh[1];
        s_d    = carry ? |in_sum[1:0] : sh[0];
    end

    // S2: a rounding carry leaves the fraction at zero and bumps the exponent
    always_comb begin
        rnd   = g_q && (r_q || s_q || man_q[0]);
        sum_m = {1'b0, man_q} + 25'(rnd);
        exp_f = exp_q + 9'(sum_m[24]);
        ovf   = !zero_q && !uf_q && exp_f >= 9'd255;
        res_d = (zero_q || uf_q) ? {sign_q, 31'b0}
              : ovf ? {sign_q, 8'hFF, 23'b0}
              : {sign_q, exp_f[7:0], sum_m[22:0]};
`ifdef FP_NR_FLAGS_EN
        flags_d = {ovf, uf_q, g_q || r_q || s_q || uf_q || ovf};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            res_q <= '0;
`ifdef FP_NR_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv2 && v1_q) res_q <= res_d;
`ifdef FP_NR_FLAGS_EN
            if (adv2 && v1_q) flags_q <= flags_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            sign_q <= sign_d;
            zero_q <= zero_d;
            uf_q   <= uf_d;
            exp_q  <= exp_d;
            man_q  <= man_d;
            g_q    <= g_d;
            r_q    <= r_d;
            s_q    <= s_d;
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed vectors for fp_norm_round, checked with immediate assertions.
module tb_fp_norm_round;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_sum = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    int          total = 0;
    int          passed = 0;
`ifdef FP_NR_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    fp_norm_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_exp(in_exp), .in_sign(in_sign), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef FP_NR_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic [27:0] s, input logic [7:0] e, input logic sg, input logic sb);
        in_valid = 1'b1;
        in_sum   = s;
        in_exp   = e;
        in_sign  = sg;
        in_sub   = sb;
    endtask

    // one transaction with out_ready=1: result must appear exactly two edges after acceptance
    task automatic send(input string tag, input logic [27:0] s, input logic [7:0] e, input logic sg,
                        input logic sb, input logic [31:0] res, input logic [2:0] fl);
        drive(s, e, sg, sb);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, out_result, res);
`ifdef FP_NR_FLAGS_EN
        check({tag, "_flg"}, 32'(out_flags), 32'(fl));
`else
        if (fl === 3'bxxx) $display("unused flags");
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_res", out_result, 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        send("add_carry",  28'h8000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 3'b000);
        send("sub_norm",   28'h8000008, 8'd127, 1'b0, 1'b1, 32'h34000000, 3'b000);
        send("sub_zero",   28'h0000000, 8'd127, 1'b1, 1'b1, 32'h00000000, 3'b000);
        send("tie_even",   28'h4000004, 8'd127, 1'b0, 1'b0, 32'h3F800000, 3'b001);
        send("tie_odd",    28'h400000C, 8'd127, 1'b0, 1'b0, 32'h3F800002, 3'b001);
        send("gr_up",      28'h4000006, 8'd127, 1'b0, 1'b0, 32'h3F800001, 3'b001);
        send("rnd_carry",  28'h7FFFFFC, 8'd127, 1'b0, 1'b0, 32'h40000000, 3'b001);
        send("rshift_rnd", 28'h8000018, 8'd127, 1'b0, 1'b0, 32'h40000002, 3'b001);
        send("overflow",   28'h8000000, 8'd254, 1'b1, 1'b0, 32'hFF800000, 3'b101);
        send("underflow",  28'h0000008, 8'd23,  1'b1, 1'b1, 32'h80000000, 3'b011);
        send("neg_exact",  28'h4000000, 8'd130, 1'b1, 1'b0, 32'hC1000000, 3'b000);

        // back-pressure: two held, third waits, then drained in order
        out_ready = 1'b0;
        drive(28'h8000000, 8'd127, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(28'h4000000, 8'd127, 1'b0, 1'b0);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(28'h4000000, 8'd130, 1'b0, 1'b0);
        check("bp_vld", 32'(out_valid), 32'd1);
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_res0", out_result, 32'h40000000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
            check("bp_hold_res", out_result, 32'h40000000);
        end
        out_ready = 1'b1;
        #1 check("bp_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_vld1", 32'(out_valid), 32'd1);
        check("bp_res1", out_result, 32'h3F800000);
        @(posedge clk); #1;
        check("bp_vld2", 32'(out_valid), 32'd1);
        check("bp_res2", out_result, 32'h41000000);
        @(posedge clk); #1;
        check("bp_drain", 32'(out_valid), 32'd0);

        // reset with both stages full
        out_ready = 1'b0;
        drive(28'h8000000, 8'd127, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(28'h4000000, 8'd127, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("fr_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("fr_vld", 32'(out_valid), 32'd0);
        check("fr_res", out_result, 32'd0);
        check("fr_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("fr_stale", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
